// File: rtl/yuv444_to_yuv422_pkg.sv
// Shared types and constants for the 4:4:4 to 4:2:2 chroma subsampler.
// The word-type encoding is kept identical to the one used by the rest of the video pipe.
package yuv444_to_yuv422_pkg;

   localparam int unsigned DTYPE_WIDTH = 3;
   localparam int unsigned META_WIDTH  = 16;

   localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL = DTYPE_WIDTH'(1);

   typedef enum logic {
      EMPTY = 1'b0,
      HOLD  = 1'b1
   } pair_state_t;

   // Type and sideband that travel unchanged with every word.
   typedef struct packed {
      logic [DTYPE_WIDTH-1:0] dtype;
      logic [META_WIDTH-1:0]  meta;
   } word_tag_t;

   function automatic logic is_pixel(input logic [DTYPE_WIDTH-1:0] dtype);
      return dtype == DTYPE_PIXEL;
   endfunction

endpackage

// File: rtl/chroma_avg.sv
// Signed rounding average of two chroma samples: (a + b + 1) >>> 1.
// One guard bit is enough, so the result always fits back into PIXEL_WIDTH.
module chroma_avg #(
   parameter int unsigned PIXEL_WIDTH = 8
) (
   input  logic [PIXEL_WIDTH-1:0] a,
   input  logic [PIXEL_WIDTH-1:0] b,
   output logic [PIXEL_WIDTH-1:0] avg_c
);

   logic signed [PIXEL_WIDTH:0] a_ext_c;
   logic signed [PIXEL_WIDTH:0] b_ext_c;
   logic signed [PIXEL_WIDTH:0] sum_c;
   logic signed [PIXEL_WIDTH:0] half_c;

   always_comb begin
      a_ext_c = $signed({a[PIXEL_WIDTH-1], a});
      b_ext_c = $signed({b[PIXEL_WIDTH-1], b});
      sum_c   = a_ext_c + b_ext_c + $signed((PIXEL_WIDTH+1)'(1));
      half_c  = sum_c >>> 1;
      avg_c   = PIXEL_WIDTH'(half_c);
   end

endmodule

// File: rtl/yuv444_to_yuv422.sv
// 4:4:4 to 4:2:2 chroma subsampler: pairs pixels, averages U onto the even and V onto
// the odd pixel, and passes non-pixel words through in order with fixed latency.
module yuv444_to_yuv422
   import yuv444_to_yuv422_pkg::*;
#(
   parameter int unsigned PIXEL_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     resetb,
   input  logic                     enable,
   input  logic                     dvi,
   input  logic [DTYPE_WIDTH-1:0]   dtypei,
   input  logic [PIXEL_WIDTH-1:0]   yi,
   input  logic [PIXEL_WIDTH-1:0]   ui,
   input  logic [PIXEL_WIDTH-1:0]   vi,
   input  logic [META_WIDTH-1:0]    meta_datai,
   output logic                     dvo,
   output logic [DTYPE_WIDTH-1:0]   dtypeo,
   output logic [2*PIXEL_WIDTH-1:0] datao,
   output logic [META_WIDTH-1:0]    meta_datao
);

   localparam int unsigned DATA_WIDTH = 2 * PIXEL_WIDTH;

   pair_state_t            state;

   // Buffered even pixel while waiting for its odd partner.
   word_tag_t              hold_tag;
   logic [PIXEL_WIDTH-1:0] hold_y;
   logic [PIXEL_WIDTH-1:0] hold_u;
   logic [PIXEL_WIDTH-1:0] hold_v;

   // Second slot: the word due one cycle after the output register.
   logic                   slot_valid;
   word_tag_t              slot_tag;
   logic [DATA_WIDTH-1:0]  slot_data;

   word_tag_t              in_tag_c;
   logic                   pair_c;
   logic [PIXEL_WIDTH-1:0] u_avg_c;
   logic [PIXEL_WIDTH-1:0] v_avg_c;

   always_comb begin
      in_tag_c.dtype = dtypei;
      in_tag_c.meta  = meta_datai;
      pair_c         = enable && is_pixel(dtypei);
   end

   chroma_avg #(
      .PIXEL_WIDTH(PIXEL_WIDTH)
   ) u_avg_u (
      .a     (hold_u),
      .b     (ui),
      .avg_c (u_avg_c)
   );

   chroma_avg #(
      .PIXEL_WIDTH(PIXEL_WIDTH)
   ) u_avg_v (
      .a     (hold_v),
      .b     (vi),
      .avg_c (v_avg_c)
   );

   // Pair FSM. A slot fill always lands in EMPTY, so the slot drains on the very next
   // edge and can never collide with a HOLD-state direct write to the output register.
   always_ff @(posedge clk) begin
      if (!resetb) begin
         state      <= EMPTY;
         hold_tag   <= '0;
         hold_y     <= '0;
         hold_u     <= '0;
         hold_v     <= '0;
         slot_valid <= 1'b0;
         slot_tag   <= '0;
         slot_data  <= '0;
         dvo        <= 1'b0;
         dtypeo     <= '0;
         datao      <= '0;
         meta_datao <= '0;
      end else begin
         dvo <= 1'b0;

         if (slot_valid) begin
            dvo        <= 1'b1;
            dtypeo     <= slot_tag.dtype;
            datao      <= slot_data;
            meta_datao <= slot_tag.meta;
            slot_valid <= 1'b0;
         end

         if (dvi) begin
            case (state)
               EMPTY: begin
                  if (pair_c) begin
                     hold_tag <= in_tag_c;
                     hold_y   <= yi;
                     hold_u   <= ui;
                     hold_v   <= vi;
                     state    <= HOLD;
                  end else begin
                     slot_valid <= 1'b1;
                     slot_tag   <= in_tag_c;
                     slot_data  <= {ui, yi};
                  end
               end
               HOLD: begin
                  // Odd partner averages; anything else flushes the held pixel as-is.
                  dvo        <= 1'b1;
                  dtypeo     <= hold_tag.dtype;
                  meta_datao <= hold_tag.meta;
                  datao      <= pair_c ? {u_avg_c, hold_y} : {hold_u, hold_y};
                  slot_valid <= 1'b1;
                  slot_tag   <= in_tag_c;
                  slot_data  <= pair_c ? {v_avg_c, yi} : {ui, yi};
                  state      <= EMPTY;
               end
               default: state <= EMPTY;
            endcase
         end
      end
   end

endmodule
